// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-cache port arbiter.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] I_BYTE_ENABLE = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between fetch, load/store queue, the arbiter and the cache.
interface mem_port_arbiter_if;
  logic        flush_valid;
  logic        i_read;
  logic [31:0] i_address;
  logic        i_resp;
  logic [31:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_wdata;
  logic        d_resp;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  // Arbiter view: it masters the cache port and answers both requesters.
  modport master (
    input  flush_valid, i_read, i_address, d_read, d_write, d_address,
           d_byte_enable, d_wdata, mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write,
           mem_address, mem_byte_enable, mem_wdata
  );

  // Environment view: requesters plus the cache.
  modport slave (
    output flush_valid, i_read, i_address, d_read, d_write, d_address,
           d_byte_enable, d_wdata, mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write,
           mem_address, mem_byte_enable, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks on the requester side of the arbiter.
module mem_port_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic i_read,
  input logic d_read,
  input logic d_write,
  input logic mem_resp,
  input logic d_resp
);

  a_d_excl: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write))
    else $error("d_read and d_write asserted together");

  // A requester may only withdraw the cycle after its transaction finished.
  a_i_hold: assert property (@(posedge clk) disable iff (!rst) $fell(i_read) |-> $past(mem_resp))
    else $error("i_read dropped before completion");

  a_d_hold: assert property (@(posedge clk) disable iff (!rst) $fell(d_read || d_write) |-> $past(d_resp))
    else $error("d request dropped before d_resp");

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between fetch (I) and the LSQ (D); D-first with an I starvation guard
// and squashing of I responses invalidated by a pipeline flush.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             squash_q, squash_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             d_req_s, i_resp_s, d_resp_s;

  assign d_req_s = bus.d_read | bus.d_write;

  // Arbitration, request latching and flush tracking.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    squash_d      = squash_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if (d_req_s && (!bus.i_read || (starve_cnt_q < LIMIT_C))) begin
          state_d       = SERVE_D;
          mem_read_d    = bus.d_read;
          mem_write_d   = bus.d_write;
          mem_address_d = bus.d_address;
          mem_be_d      = bus.d_byte_enable;
          mem_wdata_d   = bus.d_wdata;
          if (!bus.i_read) begin
            starve_cnt_d = {CNT_W{1'b0}};
          end else if (starve_cnt_q != CNT_MAX_C) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else if (bus.i_read) begin
          state_d       = SERVE_I;
          starve_cnt_d  = {CNT_W{1'b0}};
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = bus.i_address;
          mem_be_d      = I_BYTE_ENABLE;
          mem_wdata_d   = 32'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        squash_d = squash_q | bus.flush_valid;
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          squash_d    = 1'b0;
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = SERVE_D;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        squash_d    = 1'b0;
      end
    endcase
  end

  // State and cache-request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      starve_cnt_q  <= {CNT_W{1'b0}};
      squash_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'd0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      squash_q      <= squash_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Responses pass straight through; a flush on the response cycle itself still squashes.
  assign i_resp_s = (state_q == SERVE_I) && bus.mem_resp && !squash_q && !bus.flush_valid;
  assign d_resp_s = (state_q == SERVE_D) && bus.mem_resp;

  assign bus.i_resp          = i_resp_s;
  assign bus.i_rdata         = i_resp_s ? bus.mem_rdata : 32'd0;
  assign bus.d_resp          = d_resp_s;
  assign bus.d_rdata         = d_resp_s ? bus.mem_rdata : 32'd0;
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.mem_wdata       = mem_wdata_q;

  mem_port_arbiter_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .i_read   (bus.i_read),
    .d_read   (bus.d_read),
    .d_write  (bus.d_write),
    .mem_resp (bus.mem_resp),
    .d_resp   (d_resp_s)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: the bench plays fetch, LSQ and cache, and predicts every output
// from a transaction-level model of the arbitration and flush rules.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp;
  int n_mis;

  // Model: who owns the port (0 none, 1 I, 2 D), the latched request and the D streak.
  int          who;
  int          streak;
  bit          squashed;
  bit          i_done;
  bit          d_done;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  int          grants[$];
  int          i_pct, d_pct, flush_pct, resp_pct;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    who      = 0;
    streak   = 0;
    squashed = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
  endtask

  task automatic cycle();
    bit wr;
    bit exp_i;
    bit exp_d;
    @(posedge clk);
    #1;
    check_eq("mem_read", {31'd0, bus.mem_read}, {31'd0, (who == 1) || (who == 2 && !m_wr)});
    check_eq("mem_write", {31'd0, bus.mem_write}, {31'd0, (who == 2) && m_wr});
    if (who != 0) begin
      check_eq("mem_address", bus.mem_address, m_addr);
      check_eq("mem_byte_enable", {28'd0, bus.mem_byte_enable}, {28'd0, m_be});
      if (who == 2 && m_wr) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
    end
    // Requesters renew only the cycle after their transaction finished.
    if (i_done) begin
      bus.i_read = 1'b0;
      i_done = 1'b0;
    end
    if (!bus.i_read && ($urandom_range(0, 99) < i_pct)) begin
      bus.i_read    = 1'b1;
      bus.i_address = $urandom() & 32'hFFFF_FFFC;
    end
    if (d_done) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      d_done = 1'b0;
    end
    if (!(bus.d_read || bus.d_write) && ($urandom_range(0, 99) < d_pct)) begin
      wr = 1'($urandom_range(0, 1));
      bus.d_read        = !wr;
      bus.d_write       = wr;
      bus.d_address     = $urandom() & 32'hFFFF_FFFC;
      bus.d_byte_enable = 4'($urandom_range(1, 15));
      bus.d_wdata       = $urandom();
    end
    bus.flush_valid = ($urandom_range(0, 99) < flush_pct);
    bus.mem_resp    = (who != 0) && ($urandom_range(0, 99) < resp_pct);
    bus.mem_rdata   = $urandom();
    #1;
    exp_i = (who == 1) && bus.mem_resp && !squashed && !bus.flush_valid;
    exp_d = (who == 2) && bus.mem_resp;
    check_eq("i_resp", {31'd0, bus.i_resp}, {31'd0, exp_i});
    check_eq("i_rdata", bus.i_rdata, exp_i ? bus.mem_rdata : 32'd0);
    check_eq("d_resp", {31'd0, bus.d_resp}, {31'd0, exp_d});
    check_eq("d_rdata", bus.d_rdata, exp_d ? bus.mem_rdata : 32'd0);
    // Advance the model to what the next edge should produce.
    if (who == 0) begin
      if ((bus.d_read || bus.d_write) && (!bus.i_read || streak < STARVE_LIMIT)) begin
        who     = 2;
        m_wr    = bus.d_write;
        m_addr  = bus.d_address;
        m_be    = bus.d_byte_enable;
        m_wdata = bus.d_wdata;
        streak  = bus.i_read ? ((streak < 7) ? streak + 1 : 7) : 0;
        grants.push_back(2);
      end else if (bus.i_read) begin
        who    = 1;
        m_wr   = 1'b0;
        m_addr = bus.i_address;
        m_be   = 4'hF;
        streak = 0;
        grants.push_back(1);
      end
    end else begin
      if (who == 1 && bus.flush_valid) squashed = 1'b1;
      if (bus.mem_resp) begin
        if (who == 1) i_done = 1'b1;
        else d_done = 1'b1;
        who      = 0;
        squashed = 1'b0;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    bus.flush_valid = 1'b0;
    bus.i_read = 1'b0;
    bus.i_address = 32'd0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_address = 32'd0;
    bus.d_byte_enable = 4'd0;
    bus.d_wdata = 32'd0;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    check_eq("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    check_eq("rst_mem_address", bus.mem_address, 32'd0);
    check_eq("rst_mem_byte_enable", {28'd0, bus.mem_byte_enable}, 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    #2 rst = 1'b1;

    // Both requesters always pending: D four times, then I, repeating.
    i_pct = 100; d_pct = 100; flush_pct = 20; resp_pct = 100;
    grants.delete();
    repeat (60) cycle();
    check_eq("grant_count", {31'd0, grants.size() >= 15}, 32'd1);
    for (int k = 0; k < grants.size() && k < 15; k++)
      check_eq("grant_order", grants[k], (k % 5 == 4) ? 32'd1 : 32'd2);

    // Abandon a D transaction with an asynchronous reset between edges.
    i_pct = 0; d_pct = 100; flush_pct = 0; resp_pct = 0;
    for (int n = 0; n < 20 && who != 2; n++) cycle();
    cycle();
    check_eq("pre_reset_owner", who, 32'd2);
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    check_eq("arst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    check_eq("arst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    check_eq("arst_d_resp", {31'd0, bus.d_resp}, 32'd0);
    bus.mem_resp = 1'b0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.i_read = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Mixed traffic with frequent flushes and variable cache latency.
    i_pct = 40; d_pct = 40; flush_pct = 15; resp_pct = 35;
    repeat (800) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
